// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and sequencing for the 5-stage OTTER
// pipeline. Tracks register use of the instructions in EX/MEM/WB, drives
// stall/flush/bubble controls and EX operand forwarding selects, and keeps
// saturating stall/flush event counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DE_VALID,
  input  logic [4:0]       DE_RS1_ADDR,
  input  logic             DE_RS1_USED,
  input  logic [4:0]       DE_RS2_ADDR,
  input  logic             DE_RS2_USED,
  input  logic [4:0]       DE_RD_ADDR,
  input  logic             DE_RD_USED,
  input  logic             DE_IS_LOAD,
  input  logic             EX_BR_TAKEN,
  input  logic             MEM_BUSY,
  input  logic             CNT_CLR,
  output logic             PC_WRITE,
  output logic             IF_DE_WRITE,
  output logic             IF_DE_FLUSH,
  output logic             DE_EX_BUBBLE,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,  // register file value
    FWD_EX_MEM = 2'd1,  // EX/MEM alu_result
    FWD_MEM_WB = 2'd2,  // MEM/WB wb_data
    FWD_DOUT2  = 2'd3   // data-memory read data
  } fwd_sel_e;

  // Destination info: all a slot needs once it has left EX.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       rd_used;
  } dst_t;

  // MEM still needs is_load to pick dout2 over alu_result.
  typedef struct packed {
    dst_t dst;
    logic is_load;
  } mem_slot_t;

  // EX needs its sources for forwarding and is_load for load-use detection.
  typedef struct packed {
    dst_t       dst;
    logic       is_load;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
  } ex_slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ex_slot_t  r_ex;
  mem_slot_t r_mem;
  dst_t      r_wb;
  ex_slot_t  w_de;

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_redirect;
  logic w_load_use;
  logic w_ex_hit_rs1;
  logic w_ex_hit_rs2;
  logic w_mem_hit_a;
  logic w_mem_hit_b;
  logic w_wb_hit_a;
  logic w_wb_hit_b;

  // A slot produces register r only if it is live, really writes rd, and rd
  // is not x0 (x0 writes are discarded, so they never forward or stall).
  function automatic logic writes_reg(dst_t d, logic [4:0] r);
    return d.valid && d.rd_used && (d.rd != 5'd0) && (d.rd == r);
  endfunction

  // Youngest producer wins: MEM before WB, else the register file.
  function automatic logic [1:0] fwd_sel(logic ex_valid, logic used,
                                         logic mem_hit, logic mem_load,
                                         logic wb_hit);
    if (!ex_valid || !used) return FWD_RF;
    if (mem_hit)            return mem_load ? FWD_DOUT2 : FWD_EX_MEM;
    if (wb_hit)             return FWD_MEM_WB;
    return FWD_RF;
  endfunction

  assign w_ex_hit_rs1 = writes_reg(r_ex.dst, DE_RS1_ADDR) & DE_RS1_USED;
  assign w_ex_hit_rs2 = writes_reg(r_ex.dst, DE_RS2_ADDR) & DE_RS2_USED;
  assign w_mem_hit_a  = writes_reg(r_mem.dst, r_ex.rs1);
  assign w_mem_hit_b  = writes_reg(r_mem.dst, r_ex.rs2);
  assign w_wb_hit_a   = writes_reg(r_wb, r_ex.rs1);
  assign w_wb_hit_b   = writes_reg(r_wb, r_ex.rs2);

  // A busy memory defers any redirect until the pipeline moves again.
  assign w_redirect = r_ex.dst.valid & EX_BR_TAKEN & ~MEM_BUSY;
  assign w_load_use = DE_VALID & r_ex.is_load & (w_ex_hit_rs1 | w_ex_hit_rs2)
                    & ~w_redirect & ~MEM_BUSY;

  // Pipeline control: busy freeze, then redirect, then load-use stall.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    PC_WRITE     = 1'b1;
    IF_DE_WRITE  = 1'b1;
    IF_DE_FLUSH  = 1'b0;
    DE_EX_BUBBLE = 1'b0;
    if (MEM_BUSY) begin
      PC_WRITE    = 1'b0;
      IF_DE_WRITE = 1'b0;
    end else if (w_redirect) begin
      IF_DE_FLUSH  = 1'b1;
      DE_EX_BUBBLE = 1'b1;
    end else if (w_load_use) begin
      PC_WRITE     = 1'b0;
      IF_DE_WRITE  = 1'b0;
      DE_EX_BUBBLE = 1'b1;
    end
  end

  // Operand forwarding selects for the instruction in EX.
  always_comb begin
    FWD_A_SEL = fwd_sel(r_ex.dst.valid, r_ex.rs1_used, w_mem_hit_a,
                        r_mem.is_load, w_wb_hit_a);
    FWD_B_SEL = fwd_sel(r_ex.dst.valid, r_ex.rs2_used, w_mem_hit_b,
                        r_mem.is_load, w_wb_hit_b);
  end

  // Next EX slot: the DE instruction, squashed when a bubble is inserted.
  always_comb begin
    w_de = '{dst:      '{valid:   DE_VALID & ~DE_EX_BUBBLE,
                         rd:      DE_RD_ADDR,
                         rd_used: DE_RD_USED},
             is_load:  DE_IS_LOAD,
             rs1:      DE_RS1_ADDR,
             rs1_used: DE_RS1_USED,
             rs2:      DE_RS2_ADDR,
             rs2_used: DE_RS2_USED};
  end

  // Shadow slots advance with the pipeline and freeze while memory is busy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: slots must be cleared on reset; a stale valid bit would fake a hazard.
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!MEM_BUSY) begin
      // NOTE: non-blocking so every slot shifts from its pre-edge neighbour.
      r_wb  <= r_mem.dst;
      r_mem <= '{dst: r_ex.dst, is_load: r_ex.is_load};
      r_ex  <= w_de;
    end
  end

  // Saturating event counters; clear takes priority over counting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (CNT_CLR) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_load_use && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios followed by random traffic, all
// compared against an instruction-level model of the OTTER hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 8;              // narrow so saturation is reachable quickly
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       ud;
    logic       ld;
  } instr_t;

  localparam instr_t NOP = '0;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             DE_VALID, DE_RS1_USED, DE_RS2_USED, DE_RD_USED, DE_IS_LOAD;
  logic [4:0]       DE_RS1_ADDR, DE_RS2_ADDR, DE_RD_ADDR;
  logic             EX_BR_TAKEN, MEM_BUSY, CNT_CLR;
  logic             PC_WRITE, IF_DE_WRITE, IF_DE_FLUSH, DE_EX_BUBBLE;
  logic [1:0]       FWD_A_SEL, FWD_B_SEL;
  logic [CNT_W-1:0] STALL_CNT, FLUSH_CNT;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .DE_VALID(DE_VALID),
    .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS1_USED(DE_RS1_USED),
    .DE_RS2_ADDR(DE_RS2_ADDR), .DE_RS2_USED(DE_RS2_USED),
    .DE_RD_ADDR(DE_RD_ADDR),   .DE_RD_USED(DE_RD_USED),
    .DE_IS_LOAD(DE_IS_LOAD),
    .EX_BR_TAKEN(EX_BR_TAKEN), .MEM_BUSY(MEM_BUSY), .CNT_CLR(CNT_CLR),
    .PC_WRITE(PC_WRITE), .IF_DE_WRITE(IF_DE_WRITE),
    .IF_DE_FLUSH(IF_DE_FLUSH), .DE_EX_BUBBLE(DE_EX_BUBBLE),
    .FWD_A_SEL(FWD_A_SEL), .FWD_B_SEL(FWD_B_SEL),
    .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  int n_chk = 0;
  int n_err = 0;

  // Stimulus state and model state.
  instr_t de;
  logic   br, busy, clr;
  instr_t pipe[$];            // [0] = in EX, [1] = in MEM, [2] = in WB
  int     m_stall, m_flush;

  // Expected values for the current cycle.
  logic e_redirect, e_lu, e_pc, e_ifde, e_flush, e_bubble;
  int   e_fa, e_fb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(logic [4:0] rd, logic ud, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic ld);
    instr_t i;
    i = '{v: 1'b1, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, ud: ud, ld: ld};
    return i;
  endfunction

  function automatic instr_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return mk(rd, 1'b1, rs1, 1'b1, rs2, 1'b1, 1'b0);
  endfunction

  function automatic instr_t addi(logic [4:0] rd, logic [4:0] rs1);
    return mk(rd, 1'b1, rs1, 1'b1, 5'd0, 1'b0, 1'b0);
  endfunction

  function automatic instr_t lw(logic [4:0] rd, logic [4:0] rs1);
    return mk(rd, 1'b1, rs1, 1'b1, 5'd0, 1'b0, 1'b1);
  endfunction

  // An older instruction supplies register r if it is live and really writes r (never x0).
  function automatic logic produces(instr_t i, logic [4:0] r);
    return i.v && i.ud && (r != 5'd0) && (i.rd == r);
  endfunction

  // Where the EX instruction should take source r from: nearest older producer.
  function automatic int source_of(logic used, logic [4:0] r);
    if (!pipe[0].v || !used) return 0;
    if (produces(pipe[1], r)) return pipe[1].ld ? 3 : 1;
    if (produces(pipe[2], r)) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    pipe    = {NOP, NOP, NOP};
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic compute_exp();
    e_redirect = !busy && pipe[0].v && br;
    e_lu       = !busy && !e_redirect && de.v && pipe[0].ld &&
                 ((de.u1 && produces(pipe[0], de.rs1)) ||
                  (de.u2 && produces(pipe[0], de.rs2)));
    e_pc       = !busy && !e_lu;
    e_ifde     = e_pc;
    e_flush    = e_redirect;
    e_bubble   = e_redirect || e_lu;
    e_fa       = source_of(pipe[0].u1, pipe[0].rs1);
    e_fb       = source_of(pipe[0].u2, pipe[0].rs2);
  endtask

  task automatic drive();
    DE_VALID    = de.v;
    DE_RS1_ADDR = de.rs1;
    DE_RS1_USED = de.u1;
    DE_RS2_ADDR = de.rs2;
    DE_RS2_USED = de.u2;
    DE_RD_ADDR  = de.rd;
    DE_RD_USED  = de.ud;
    DE_IS_LOAD  = de.ld;
    EX_BR_TAKEN = br;
    MEM_BUSY    = busy;
    CNT_CLR     = clr;
  endtask

  task automatic check_all(input string tag);
    compute_exp();
    chk({tag, ".pc_write"},    32'(PC_WRITE),     32'(e_pc));
    chk({tag, ".if_de_write"}, 32'(IF_DE_WRITE),  32'(e_ifde));
    chk({tag, ".if_de_flush"}, 32'(IF_DE_FLUSH),  32'(e_flush));
    chk({tag, ".bubble"},      32'(DE_EX_BUBBLE), 32'(e_bubble));
    chk({tag, ".fwd_a"},       32'(FWD_A_SEL),    32'(e_fa));
    chk({tag, ".fwd_b"},       32'(FWD_B_SEL),    32'(e_fb));
    chk({tag, ".stall_cnt"},   32'(STALL_CNT),    32'(m_stall));
    chk({tag, ".flush_cnt"},   32'(FLUSH_CNT),    32'(m_flush));
  endtask

  // One clock: apply inputs, compare, take the edge, advance the model.
  // Entered and left 1 time unit after a rising edge.
  task automatic step(input string tag);
    instr_t n;
    drive();
    #1;
    check_all(tag);
    @(posedge CLK);
    if (!busy) begin
      n   = de;
      n.v = de.v && !e_bubble;
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e_lu && m_stall < CMAX)       m_stall++;
      if (e_redirect && m_flush < CMAX) m_flush++;
    end
    #1;
  endtask

  // Apply inputs and let them settle without clocking, for explicit checks.
  task automatic peek();
    drive();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    de = NOP; br = 1'b0; busy = 1'b0; clr = 1'b0;
    model_reset();
    drive();
    #3;
    check_all("reset");
    chk("reset.pc_const", 32'(PC_WRITE), 1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in DE -> one stall cycle.
    de = lw(5'd5, 5'd2);       step("lu.lw");
    de = alu(5'd6, 5'd5, 5'd1); peek();
    chk("lu.bubble", 32'(DE_EX_BUBBLE), 1);
    chk("lu.pc",     32'(PC_WRITE), 0);
    chk("lu.ifde",   32'(IF_DE_WRITE), 0);
    step("lu.stall");
    peek();
    chk("lu.stall_cnt", 32'(STALL_CNT), 1);
    chk("lu.no_2nd",    32'(DE_EX_BUBBLE), 0);
    step("lu.hold");
    // The ADD reaches EX as the load reaches WB.
    de = NOP; peek();
    chk("lu.fwd_a", 32'(FWD_A_SEL), 2);
    step("lu.use");

    // Back-to-back ALU dependency, then with one NOP between.
    de = alu(5'd3, 5'd1, 5'd2); step("b2b.add");
    de = alu(5'd4, 5'd3, 5'd3); step("b2b.sub");
    de = NOP; peek();
    chk("b2b.fwd_a", 32'(FWD_A_SEL), 1);
    chk("b2b.fwd_b", 32'(FWD_B_SEL), 1);
    chk("b2b.pc",    32'(PC_WRITE), 1);
    step("b2b.use");
    de = alu(5'd3, 5'd1, 5'd2); step("gap.add");
    de = NOP;                   step("gap.nop");
    de = alu(5'd4, 5'd3, 5'd3); step("gap.sub");
    de = NOP; peek();
    chk("gap.fwd_a", 32'(FWD_A_SEL), 2);
    chk("gap.fwd_b", 32'(FWD_B_SEL), 2);
    step("gap.use");

    // Two writers of x7: the younger (MEM) wins; x0 source never forwards.
    de = addi(5'd7, 5'd1);      step("pri.addi1");
    de = addi(5'd7, 5'd2);      step("pri.addi2");
    de = alu(5'd8, 5'd7, 5'd0); step("pri.or");
    de = NOP; peek();
    chk("pri.fwd_a", 32'(FWD_A_SEL), 1);
    chk("pri.fwd_b", 32'(FWD_B_SEL), 0);
    step("pri.use");
    de = addi(5'd0, 5'd1);      step("x0.write");
    de = alu(5'd9, 5'd0, 5'd0); step("x0.read");
    de = NOP; peek();
    chk("x0.fwd_a", 32'(FWD_A_SEL), 0);
    chk("x0.fwd_b", 32'(FWD_B_SEL), 0);
    step("x0.use");

    // Taken redirect overrides a pending load-use stall.
    de = lw(5'd5, 5'd2);        step("br.lw");
    de = alu(5'd6, 5'd5, 5'd1); br = 1'b1; peek();
    chk("br.flush",  32'(IF_DE_FLUSH), 1);
    chk("br.bubble", 32'(DE_EX_BUBBLE), 1);
    chk("br.pc",     32'(PC_WRITE), 1);
    chk("br.ifde",   32'(IF_DE_WRITE), 1);
    step("br.redirect");
    br = 1'b0; de = NOP; peek();
    chk("br.flush_cnt", 32'(FLUSH_CNT), 1);
    chk("br.stall_cnt", 32'(STALL_CNT), 1);
    step("br.after");

    // MEM_BUSY freezes everything; the deferred redirect fires when it drops.
    de = lw(5'd5, 5'd2);        step("busy.lw");
    de = alu(5'd6, 5'd5, 5'd1); br = 1'b1; busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      peek();
      chk("busy.pc",     32'(PC_WRITE), 0);
      chk("busy.flush",  32'(IF_DE_FLUSH), 0);
      chk("busy.bubble", 32'(DE_EX_BUBBLE), 0);
      step("busy.hold");
    end
    busy = 1'b0; peek();
    chk("busy.release_flush", 32'(IF_DE_FLUSH), 1);
    step("busy.release");
    br = 1'b0; de = NOP; peek();
    chk("busy.flush_cnt", 32'(FLUSH_CNT), 2);
    chk("busy.stall_cnt", 32'(STALL_CNT), 1);
    step("busy.after");

    // Saturation: a self-dependent load chain stalls every other cycle.
    de = lw(5'd5, 5'd5);
    for (int i = 0; i < 1000 && m_stall < CMAX; i++) step("sat.fill");
    repeat (4) step("sat.more");
    peek();
    chk("sat.stall_cnt", 32'(STALL_CNT), CMAX);
    clr = 1'b1; step("sat.clr");
    clr = 1'b0; de = NOP; peek();
    chk("clr.stall_cnt", 32'(STALL_CNT), 0);
    chk("clr.flush_cnt", 32'(FLUSH_CNT), 0);
    step("clr.after");

    // Asynchronous reset in the middle of a stall.
    de = lw(5'd5, 5'd2);        step("rst.lw");
    de = alu(5'd6, 5'd5, 5'd1); peek();
    chk("rst.pre_bubble", 32'(DE_EX_BUBBLE), 1);
    RST = 1'b1;
    #1;
    model_reset();
    chk("rst.pc",     32'(PC_WRITE), 1);
    chk("rst.bubble", 32'(DE_EX_BUBBLE), 0);
    check_all("rst.async");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Random traffic on a small register set so hazards are frequent.
    for (int i = 0; i < 2000; i++) begin
      de.v   = ($urandom_range(0, 3) != 0);
      de.rs1 = 5'($urandom_range(0, 3));
      de.u1  = 1'($urandom_range(0, 1));
      de.rs2 = 5'($urandom_range(0, 3));
      de.u2  = 1'($urandom_range(0, 1));
      de.rd  = 5'($urandom_range(0, 3));
      de.ud  = 1'($urandom_range(0, 1));
      de.ld  = ($urandom_range(0, 2) == 0);
      br     = ($urandom_range(0, 3) == 0);
      busy   = ($urandom_range(0, 4) == 0);
      clr    = !busy && ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
